// File: rtl/mem_bus_arbiter.sv
// Shares one memory bus between fetch (i_*) and load/store (d_*); data first, fetch forced after MAX_D_STREAK data grants.
// Min latency: grant edge N, ack pulse after N+1, next grant N+3; requesters hold req (stall high) until their ack.
module mem_bus_arbiter #(
   parameter int MAX_D_STREAK = 4,
   parameter int TIMEOUT      = 16,
   parameter int CNT_W        = 5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_req,
   input  logic [31:0] i_addr,
   output logic        i_ack,
   output logic [31:0] i_rdata,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [1:0]  d_size,
   input  logic [31:0] d_wdata,
   output logic        d_ack,
   output logic [31:0] d_rdata,
   output logic        err,
   output logic        stall,
   output logic [31:0] bus_addr,
   output logic        bus_mreq,
   output logic        bus_write,
   output logic [1:0]  bus_size,
   output logic [31:0] bus_wdata,
   input  logic [31:0] bus_rdata,
   input  logic        bus_ack_n
);

   typedef enum logic [1:0] {IDLE, D_BUSY, I_BUSY, DONE} state_t;

   localparam logic [CNT_W-1:0] STREAK_MAX   = CNT_W'(MAX_D_STREAK);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);

   state_t           state;
   logic [CNT_W-1:0] wait_cnt;
   logic [CNT_W-1:0] d_streak;
   logic             d_legal;
   logic             data_grant;
   logic             bus_acked;
   logic             timed_out;

   // Data wins unless a fetch has already waited out MAX_D_STREAK data grants.
   assign d_legal    = (d_size != 2'b11);
   assign data_grant = d_req && !(i_req && (d_streak == STREAK_MAX));
   assign bus_acked  = !bus_ack_n;
   assign timed_out  = (wait_cnt == TIMEOUT_LAST);
   assign stall      = (i_req | d_req) & ~(i_ack | d_ack);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         wait_cnt  <= '0;
         d_streak  <= '0;
         i_ack     <= 1'b0;
         d_ack     <= 1'b0;
         err       <= 1'b0;
         i_rdata   <= '0;
         d_rdata   <= '0;
         bus_addr  <= '0;
         bus_mreq  <= 1'b0;
         bus_write <= 1'b0;
         bus_size  <= '0;
         bus_wdata <= '0;
      end else begin
         i_ack <= 1'b0;
         d_ack <= 1'b0;
         err   <= 1'b0;
         if (!i_req) d_streak <= '0;

         case (state)
            IDLE: begin
               wait_cnt <= '0;
               if (data_grant) begin
                  if (i_req) d_streak <= d_streak + 1'b1;
                  if (d_legal) begin
                     bus_addr  <= d_addr;
                     bus_write <= d_we;
                     bus_size  <= d_size;
                     bus_wdata <= d_wdata;
                     bus_mreq  <= 1'b1;
                     state     <= D_BUSY;
                  end else begin
                     // Illegal size never reaches the bus; fail it straight away.
                     d_ack <= 1'b1;
                     err   <= 1'b1;
                     state <= DONE;
                  end
               end else if (i_req) begin
                  d_streak  <= '0;
                  bus_addr  <= i_addr;
                  bus_size  <= 2'b00;
                  bus_write <= 1'b0;
                  bus_mreq  <= 1'b1;
                  state     <= I_BUSY;
               end
            end

            D_BUSY, I_BUSY: begin
               if (bus_acked || timed_out) begin
                  bus_mreq  <= 1'b0;
                  bus_write <= 1'b0;
                  wait_cnt  <= '0;
                  err       <= !bus_acked;
                  state     <= DONE;
                  if (state == D_BUSY) begin
                     d_ack <= 1'b1;
                     if (!bus_acked)     d_rdata <= '0;
                     else if (!bus_write) d_rdata <= bus_rdata;
                  end else begin
                     i_ack   <= 1'b1;
                     i_rdata <= bus_acked ? bus_rdata : 32'h0;
                  end
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end

            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: load, priority, starvation guard, timeout, illegal size, reset mid-access.
module tb_mem_bus_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_req;
   logic [31:0] i_addr;
   logic        i_ack;
   logic [31:0] i_rdata;
   logic        d_req;
   logic        d_we;
   logic [31:0] d_addr;
   logic [1:0]  d_size;
   logic [31:0] d_wdata;
   logic        d_ack;
   logic [31:0] d_rdata;
   logic        err;
   logic        stall;
   logic [31:0] bus_addr;
   logic        bus_mreq;
   logic        bus_write;
   logic [1:0]  bus_size;
   logic [31:0] bus_wdata;
   logic [31:0] bus_rdata;
   logic        bus_ack_n;

   logic        auto_ack;
   logic        force_ack_n;

   int checks = 0;
   int errors = 0;

   // Memory model: with auto_ack it acknowledges in the first cycle mreq is high.
   assign bus_ack_n = auto_ack ? ~bus_mreq : force_ack_n;

   always #5 clk = ~clk;

   mem_bus_arbiter #(.MAX_D_STREAK(4), .TIMEOUT(16), .CNT_W(5)) dut (
      .clk(clk), .rst(rst),
      .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_size(d_size), .d_wdata(d_wdata),
      .d_ack(d_ack), .d_rdata(d_rdata), .err(err), .stall(stall),
      .bus_addr(bus_addr), .bus_mreq(bus_mreq), .bus_write(bus_write), .bus_size(bus_size),
      .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack_n(bus_ack_n)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; i_req = 1'b0; d_req = 1'b0; i_addr = '0; d_addr = '0; d_we = 1'b0;
      d_size = 2'b00; d_wdata = '0; bus_rdata = '0; auto_ack = 1'b0; force_ack_n = 1'b1;
      tick(); tick();
      checks++;
      if (bus_mreq !== 1'b0 || bus_write !== 1'b0 || bus_addr !== 32'h0 || bus_size !== 2'b00) begin
         errors++; $display("FAIL reset_bus mreq=%b write=%b addr=%h size=%b want all 0", bus_mreq, bus_write, bus_addr, bus_size);
      end
      checks++;
      if (i_ack !== 1'b0 || d_ack !== 1'b0 || err !== 1'b0 || stall !== 1'b0) begin
         errors++; $display("FAIL reset_flags i_ack=%b d_ack=%b err=%b stall=%b want 0", i_ack, d_ack, err, stall);
      end
      checks++;
      if (i_rdata !== 32'h0 || d_rdata !== 32'h0 || bus_wdata !== 32'h0) begin
         errors++; $display("FAIL reset_data i_rdata=%h d_rdata=%h wdata=%h want 0", i_rdata, d_rdata, bus_wdata);
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_single_load();
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100; d_size = 2'b00;
      bus_rdata = 32'hDEADBEEF; auto_ack = 1'b1;
      #1;
      checks++;
      if (stall !== 1'b1) begin errors++; $display("FAIL load_stall got %b want 1", stall); end
      tick();
      checks++;
      if (bus_mreq !== 1'b1 || bus_addr !== 32'h100 || bus_write !== 1'b0 || d_ack !== 1'b0) begin
         errors++; $display("FAIL load_grant mreq=%b addr=%h write=%b d_ack=%b want 1/100/0/0", bus_mreq, bus_addr, bus_write, d_ack);
      end
      tick();
      checks++;
      if (bus_mreq !== 1'b0 || d_ack !== 1'b1 || d_rdata !== 32'hDEADBEEF || err !== 1'b0 || i_ack !== 1'b0) begin
         errors++; $display("FAIL load_ack mreq=%b d_ack=%b rdata=%h err=%b i_ack=%b want 0/1/deadbeef/0/0", bus_mreq, d_ack, d_rdata, err, i_ack);
      end
      checks++;
      if (stall !== 1'b0) begin errors++; $display("FAIL load_stall_release got %b want 0", stall); end
      d_req = 1'b0;
      tick();
      checks++;
      if (d_ack !== 1'b0 || bus_mreq !== 1'b0 || bus_write !== 1'b0) begin
         errors++; $display("FAIL load_done d_ack=%b mreq=%b write=%b want 0", d_ack, bus_mreq, bus_write);
      end
      tick();
   endtask

   task automatic test_priority();
      i_req = 1'b1; i_addr = 32'h2000;
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h300; d_size = 2'b10; d_wdata = 32'h55;
      bus_rdata = 32'h13; auto_ack = 1'b1;
      tick();
      checks++;
      if (bus_mreq !== 1'b1 || bus_write !== 1'b1 || bus_size !== 2'b10 || bus_wdata !== 32'h55 || bus_addr !== 32'h300) begin
         errors++; $display("FAIL prio_data_first mreq=%b write=%b size=%b wdata=%h addr=%h want 1/1/10/55/300",
                            bus_mreq, bus_write, bus_size, bus_wdata, bus_addr);
      end
      tick();
      checks++;
      if (d_ack !== 1'b1 || i_ack !== 1'b0 || bus_write !== 1'b0 || d_rdata !== 32'hDEADBEEF) begin
         errors++; $display("FAIL prio_store_ack d_ack=%b i_ack=%b write=%b d_rdata=%h want 1/0/0/deadbeef", d_ack, i_ack, bus_write, d_rdata);
      end
      d_req = 1'b0;
      tick();
      checks++;
      if (bus_mreq !== 1'b0 || d_ack !== 1'b0) begin
         errors++; $display("FAIL prio_done_idle mreq=%b d_ack=%b want 0/0", bus_mreq, d_ack);
      end
      tick();
      checks++;
      if (bus_mreq !== 1'b1 || bus_addr !== 32'h2000 || bus_size !== 2'b00 || bus_write !== 1'b0) begin
         errors++; $display("FAIL prio_fetch_grant mreq=%b addr=%h size=%b write=%b want 1/2000/00/0", bus_mreq, bus_addr, bus_size, bus_write);
      end
      tick();
      checks++;
      if (i_ack !== 1'b1 || i_rdata !== 32'h13 || d_ack !== 1'b0 || err !== 1'b0) begin
         errors++; $display("FAIL prio_fetch_ack i_ack=%b i_rdata=%h d_ack=%b err=%b want 1/13/0/0", i_ack, i_rdata, d_ack, err);
      end
      i_req = 1'b0;
      tick(); tick();
   endtask

   task automatic test_starvation();
      logic [31:0] grants [6];
      int          n_grants = 0;
      int          d_acks = 0;
      int          d_before_i = -1;
      logic        prev_mreq = 1'b0;
      logic        both_acks = 1'b0;
      i_req = 1'b1; i_addr = 32'h800;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h400; d_size = 2'b00;
      auto_ack = 1'b1; bus_rdata = 32'h1234;
      for (int c = 0; c < 40 && n_grants < 6; c++) begin
         tick();
         if (bus_mreq && !prev_mreq) begin grants[n_grants] = bus_addr; n_grants++; end
         prev_mreq = bus_mreq;
         if (i_ack && d_ack) both_acks = 1'b1;
         if (d_ack) d_acks++;
         if (i_ack && d_before_i < 0) d_before_i = d_acks;
      end
      i_req = 1'b0; d_req = 1'b0;
      checks++;
      if (n_grants != 6) begin errors++; $display("FAIL starve_grant_count got %0d want 6", n_grants); end
      for (int g = 0; g < 6; g++) begin
         if (g < n_grants) begin
            checks++;
            if (grants[g] !== ((g == 4) ? 32'h800 : 32'h400)) begin
               errors++; $display("FAIL starve_order grant %0d addr=%h want %h", g, grants[g], (g == 4) ? 32'h800 : 32'h400);
            end
         end
      end
      checks++;
      if (d_before_i != 4) begin errors++; $display("FAIL starve_i_ack_after data_acks=%0d want 4", d_before_i); end
      checks++;
      if (both_acks) begin errors++; $display("FAIL starve_dual_ack got both acks high want never"); end
      tick(); tick(); tick(); tick();
   endtask

   task automatic test_timeout();
      int mreq_cycles = 0;
      auto_ack = 1'b0; force_ack_n = 1'b1; bus_rdata = 32'hFFFFFFFF;
      i_req = 1'b1; i_addr = 32'h900;
      for (int c = 0; c < 30; c++) begin
         tick();
         if (bus_mreq) mreq_cycles++;
         else if (mreq_cycles > 0) break;
         if (i_ack) break;
      end
      checks++;
      if (mreq_cycles != 16) begin errors++; $display("FAIL timeout_mreq_cycles got %0d want 16", mreq_cycles); end
      checks++;
      if (bus_mreq !== 1'b0 || i_ack !== 1'b1 || err !== 1'b1 || i_rdata !== 32'h0) begin
         errors++; $display("FAIL timeout_abort mreq=%b i_ack=%b err=%b i_rdata=%h want 0/1/1/0", bus_mreq, i_ack, err, i_rdata);
      end
      i_req = 1'b0;
      tick();
      checks++;
      if (i_ack !== 1'b0 || err !== 1'b0) begin
         errors++; $display("FAIL timeout_pulse i_ack=%b err=%b want 0/0", i_ack, err);
      end
      tick();
   endtask

   task automatic test_illegal_size();
      auto_ack = 1'b0; force_ack_n = 1'b1;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h600; d_size = 2'b11;
      tick();
      checks++;
      if (bus_mreq !== 1'b0 || d_ack !== 1'b1 || err !== 1'b1 || i_ack !== 1'b0) begin
         errors++; $display("FAIL illegal_size mreq=%b d_ack=%b err=%b i_ack=%b want 0/1/1/0", bus_mreq, d_ack, err, i_ack);
      end
      d_req = 1'b0; d_size = 2'b00;
      tick();
      checks++;
      if (d_ack !== 1'b0 || err !== 1'b0 || bus_mreq !== 1'b0) begin
         errors++; $display("FAIL illegal_pulse d_ack=%b err=%b mreq=%b want 0", d_ack, err, bus_mreq);
      end
      // Spurious ack while idle must be ignored.
      force_ack_n = 1'b0;
      tick(); tick();
      checks++;
      if (d_ack !== 1'b0 || i_ack !== 1'b0 || err !== 1'b0 || bus_mreq !== 1'b0) begin
         errors++; $display("FAIL idle_spurious_ack d_ack=%b i_ack=%b err=%b mreq=%b want 0", d_ack, i_ack, err, bus_mreq);
      end
      force_ack_n = 1'b1;
      tick();
   endtask

   task automatic test_reset_mid_access();
      auto_ack = 1'b0; force_ack_n = 1'b1;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h500; d_size = 2'b00;
      tick();
      checks++;
      if (bus_mreq !== 1'b1) begin errors++; $display("FAIL rstmid_grant mreq=%b want 1", bus_mreq); end
      tick();
      rst = 1'b1;
      tick();
      checks++;
      if (bus_mreq !== 1'b0 || d_ack !== 1'b0 || err !== 1'b0 || d_rdata !== 32'h0) begin
         errors++; $display("FAIL rstmid_abort mreq=%b d_ack=%b err=%b d_rdata=%h want 0", bus_mreq, d_ack, err, d_rdata);
      end
      rst = 1'b0; auto_ack = 1'b1; bus_rdata = 32'hCAFEF00D;
      tick();
      checks++;
      if (bus_mreq !== 1'b1 || bus_addr !== 32'h500 || d_ack !== 1'b0) begin
         errors++; $display("FAIL rstmid_regrant mreq=%b addr=%h d_ack=%b want 1/500/0", bus_mreq, bus_addr, d_ack);
      end
      tick();
      checks++;
      if (d_ack !== 1'b1 || d_rdata !== 32'hCAFEF00D || err !== 1'b0) begin
         errors++; $display("FAIL rstmid_reload d_ack=%b d_rdata=%h err=%b want 1/cafef00d/0", d_ack, d_rdata, err);
      end
      d_req = 1'b0;
      tick(); tick();
   endtask

   initial begin
      test_reset();
      test_single_load();
      test_priority();
      test_starvation();
      test_timeout();
      test_illegal_size();
      test_reset_mid_access();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish in time");
      $fatal(1);
   end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares one external memory bus (address, MREQ, WRITE, SIZE, data, active-low ACK) between two requesters: the IF stage (instruction fetch) and the MEM stage (load/store).
- Owns the request/acknowledge handshake, bus wait states, fixed data-first priority with an instruction anti-starvation guard, and an ack timeout.
- Drives a stall signal so the pipeline can freeze while an access is outstanding.
- Sits between the pipeline stages and the top-level bus pins.

Parameters:
- MAX_D_STREAK, 4: consecutive data grants allowed while i_req is pending before instruction is forced.
- TIMEOUT, 16: cycles in a BUSY state without ack before the access is aborted with err.
- CNT_W, 5: width of the internal wait and streak counters; must hold max(TIMEOUT, MAX_D_STREAK).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- i_req  in  1  instruction fetch request; held until i_ack.
- i_addr  in  32  fetch address.
- i_ack  out  1  one-cycle pulse; fetch done, i_rdata valid.
- i_rdata  out  32  fetched instruction.
- d_req  in  1  data access request; held until d_ack.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  32  data address.
- d_size  in  2  00 WORD, 01 HALF, 10 BYTE, 11 illegal.
- d_wdata  in  32  store data.
- d_ack  out  1  one-cycle pulse; data access done, d_rdata valid for loads.
- d_rdata  out  32  load data.
- err  out  1  one-cycle pulse coincident with i_ack/d_ack when the access was aborted.
- stall  out  1  high while any request is pending and not yet acked.
- bus_addr  out  32  registered bus address.
- bus_mreq  out  1  registered; high for the duration of every bus access.
- bus_write  out  1  registered; high for store accesses only.
- bus_size  out  2  registered access size; 00 for fetches.
- bus_wdata  out  32  registered store data; top level drives the tristate from it.
- bus_rdata  in  32  read data from the bus.
- bus_ack_n  in  1  active-low acknowledge from memory.

Behaviour:
- Reset values: all registered outputs 0, state IDLE, counters 0. Reset asserted mid-access drops bus_mreq at the same edge and emits no ack.
- FSM states: IDLE, D_BUSY, I_BUSY, DONE.
- IDLE, d_req=1 with legal d_size: latch d_addr/d_we/d_size/d_wdata into the bus registers; bus_mreq=1; bus_write=d_we; go to D_BUSY.
- IDLE, d_req=1 with d_size=11: no bus cycle; go to DONE with d_ack and err set.
- IDLE, i_req=1 and no data grant (d_req=0, or d_streak==MAX_D_STREAK): bus_addr=i_addr, bus_size=00, bus_write=0, bus_mreq=1; go to I_BUSY.
- d_streak: increments on each data grant made while i_req=1; clears on an instruction grant or whenever i_req=0.
- D_BUSY / I_BUSY, bus_ack_n sampled 0: capture bus_rdata into d_rdata or i_rdata (d_rdata is unchanged for stores); drop bus_mreq and bus_write; go to DONE with the matching ack.
- D_BUSY / I_BUSY, no ack: wait counter increments. When it reaches TIMEOUT-1 without ack: abort, rdata=0, err=1, drop bus_mreq, go to DONE.
- DONE: lasts exactly one cycle; ack (and err if set) high; requests are ignored; next state IDLE. This gives the requester one edge to deassert req.
- Minimum latency: req high before edge N → bus_mreq high after N → ack_n low sampled at N+1 → ack high in cycle N+1 → IDLE after N+2 → earliest next grant at edge N+3.
- stall = (i_req | d_req) & ~(i_ack | d_ack), combinational.
- Only one ack is pulsed per DONE cycle; i_ack and d_ack are never high together.
- A bus_ack_n low while in IDLE or DONE is ignored.

Test Plan:
- Single load: d_req, d_addr=0x100, d_size=00, bus acks 1 cycle after mreq with rdata=0xDEADBEEF → bus_mreq high exactly 1 cycle; d_ack pulse with d_rdata=0xDEADBEEF; bus_write=0 throughout.
- Simultaneous i_req and d_req (store, d_wdata=0x55, size=10) → data granted first, bus_write=1, bus_size=10, bus_wdata=0x55; fetch granted at the edge after DONE.
- Starvation: d_req and i_req held high continuously, instant acks → grant order D,D,D,D,I,D,...; i_ack arrives after exactly 4 data acks.
- Timeout: i_req with bus_ack_n held 1 → bus_mreq drops after 16 cycles; i_ack and err pulse together; i_rdata=0.
- Illegal size: d_req with d_size=11 → no bus_mreq; d_ack and err asserted 1 cycle after the request is sampled.
- Reset mid-access: rst asserted during D_BUSY → after that edge bus_mreq=0, no d_ack, state IDLE; a subsequent load completes normally.
